// File: rtl/mem_port_responder.sv
// Fixed-latency word-addressed memory responder for the CPU imem/dmem request port.
// Define MEM_PROTOCOL_CHECK_EN to build the sticky protocol_err checker.
module mem_port_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        protocol_err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) + 1 : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          op_wr;
    logic [AW-1:0] idx;
    logic [3:0]    wmask_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] req_idx;
    logic          req;
    logic          enter_resp;
    logic          cur_wr;
    logic [AW-1:0] cur_idx;
    logic [3:0]    cur_wmask;
    logic [31:0]   cur_wdata;
    logic          unused_offset_bits;

    assign offset             = mem_address - BASE_ADDR;
    assign req_idx            = offset[AW+1:2];
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};
    assign req                = mem_read | mem_write;

    // With LATENCY=1 the commit happens on the accepting edge, so the live inputs are used.
    assign cur_wr    = (state == IDLE) ? mem_write   : op_wr;
    assign cur_idx   = (state == IDLE) ? req_idx     : idx;
    assign cur_wmask = (state == IDLE) ? mem_wmask   : wmask_q;
    assign cur_wdata = (state == IDLE) ? mem_wdata   : wdata_q;

    always_comb begin
        enter_resp = 1'b0;
        case (state)
            IDLE:    enter_resp = req && (LATENCY == 1);
            BUSY:    enter_resp = req && (count == CW'(1));
            default: enter_resp = 1'b0;
        endcase
        if (rst) enter_resp = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (enter_resp && cur_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (cur_wmask[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
            op_wr     <= 1'b0;
            idx       <= '0;
            wmask_q   <= '0;
            wdata_q   <= '0;
        end else begin
            mem_resp <= enter_resp;
            if (enter_resp && !cur_wr) mem_rdata <= mem[cur_idx];
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr   <= mem_write;
                        idx     <= req_idx;
                        wmask_q <= mem_wmask;
                        wdata_q <= mem_wdata;
                        count   <= CW'(LATENCY - 1);
                        state   <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    count <= count - CW'(1);
                    if (!req)                    state <= IDLE;
                    else if (count == CW'(1))    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_PROTOCOL_CHECK_EN
    logic [31:0] addr_q;
    logic        held_changed;

    assign held_changed = (mem_write != op_wr) || (mem_address != addr_q) ||
                          (mem_wdata != wdata_q) || (mem_wmask != wmask_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (state == IDLE && req) addr_q <= mem_address;
            if ((mem_read && mem_write) ||
                (state == BUSY && !req) ||
                (state == BUSY && req && held_changed))
                protocol_err <= 1'b1;
        end
    end
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed self-checking bench: three responders with LATENCY 1, 2 and 3
// (the third with DEPTH_WORDS=64 and BASE_ADDR=32'h100).
module tb_mem_port_responder;
    logic        clk;
    logic        rst;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [3:0]  wm [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic [2:0]  resp;
    logic [2:0]  perr;
    logic [31:0] rdata [3];

    int n_cmp;
    int n_bad;

`ifdef MEM_PROTOCOL_CHECK_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    mem_port_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_lat1 (
        .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]), .mem_wmask(wm[0]),
        .mem_address(ad[0]), .mem_wdata(wd[0]), .mem_resp(resp[0]), .mem_rdata(rdata[0]),
        .protocol_err(perr[0]));

    mem_port_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_lat2 (
        .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]), .mem_wmask(wm[1]),
        .mem_address(ad[1]), .mem_wdata(wd[1]), .mem_resp(resp[1]), .mem_rdata(rdata[1]),
        .protocol_err(perr[1]));

    mem_port_responder #(.DEPTH_WORDS(64), .LATENCY(3), .BASE_ADDR(32'h0000_0100)) u_lat3 (
        .clk(clk), .rst(rst), .mem_read(rd[2]), .mem_write(wr[2]), .mem_wmask(wm[2]),
        .mem_address(ad[2]), .mem_wdata(wd[2]), .mem_resp(resp[2]), .mem_rdata(rdata[2]),
        .protocol_err(perr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request on instance k (latency k+1) from a negedge and watches
    // latency+2 negedges; the request is dropped on the negedge where resp is seen.
    task automatic run_txn(input int k, input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m,
                           output int first, output int cnt, output logic [31:0] data);
        first = -1;
        cnt   = 0;
        data  = '0;
        rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d; wm[k] = m;
        for (int i = 1; i <= k + 3; i++) begin
            @(negedge clk);
            if (resp[k]) begin
                cnt++;
                if (first < 0) begin
                    first = i;
                    data  = rdata[k];
                end
                rd[k] = 1'b0;
                wr[k] = 1'b0;
            end
        end
        rd[k] = 1'b0;
        wr[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (resp !== 3'b000) begin n_bad++; $display("FAIL reset_resp: got %b want 000", resp); end
        n_cmp++; if (perr !== 3'b000) begin n_bad++; $display("FAIL reset_perr: got %b want 000", perr); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (rdata[k] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata%0d: got %h want 0", k, rdata[k]); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_read();
        int f, c;
        logic [31:0] d;
        run_txn(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, f, c, d);
        n_cmp++; if (f !== 2) begin n_bad++; $display("FAIL basic_wr_lat: got %0d want 2", f); end
        n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL basic_wr_cnt: got %0d want 1", c); end
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL basic_wr_rdata_hold: got %h want 0", d); end
        run_txn(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, f, c, d);
        n_cmp++; if (f !== 2) begin n_bad++; $display("FAIL basic_rd_lat: got %0d want 2", f); end
        n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL basic_rd_cnt: got %0d want 1", c); end
        n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL basic_rd_data: got %h want deadbeef", d); end
    endtask

    task automatic test_masked_write();
        int f, c;
        logic [31:0] d;
        run_txn(1, 1'b0, 1'b1, 32'h4, 32'h1122_3344, 4'hF, f, c, d);
        run_txn(1, 1'b0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, f, c, d);
        run_txn(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, f, c, d);
        n_cmp++; if (d !== 32'h11BB_33DD) begin n_bad++; $display("FAIL masked_data: got %h want 11bb33dd", d); end
        run_txn(1, 1'b0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'h0, f, c, d);
        n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL mask0_resp_cnt: got %0d want 1", c); end
        run_txn(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, f, c, d);
        n_cmp++; if (d !== 32'h11BB_33DD) begin n_bad++; $display("FAIL mask0_noop: got %h want 11bb33dd", d); end
    endtask

    task automatic test_back_to_back();
        int f, c;
        logic [31:0] d;
        logic [31:0] addrs [3];
        logic [31:0] vals [3];
        addrs[0] = 32'h20; addrs[1] = 32'h24; addrs[2] = 32'h28;
        vals[0] = 32'hA000_0001; vals[1] = 32'hB000_0002; vals[2] = 32'hC000_0003;
        for (int j = 0; j < 3; j++) run_txn(0, 1'b0, 1'b1, addrs[j], vals[j], 4'hF, f, c, d);
        n_cmp++; if (f !== 1) begin n_bad++; $display("FAIL b2b_wr_lat: got %0d want 1", f); end
        rd[0] = 1'b1; ad[0] = addrs[0];
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            n_cmp++; if (resp[0] !== 1'(i % 2)) begin n_bad++; $display("FAIL b2b_resp_c%0d: got %b want %b", i, resp[0], 1'(i % 2)); end
            if (i % 2 == 1) begin
                n_cmp++; if (rdata[0] !== vals[(i-1)/2]) begin n_bad++; $display("FAIL b2b_data_c%0d: got %h want %h", i, rdata[0], vals[(i-1)/2]); end
                if (i < 5) ad[0] = addrs[(i+1)/2];
                else       rd[0] = 1'b0;
            end
        end
    endtask

    task automatic test_read_after_write();
        wr[0] = 1'b1; ad[0] = 32'h40; wd[0] = 32'hCAFE_F00D; wm[0] = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_cmp++; if (resp[0] !== (i == 1 || i == 3)) begin n_bad++; $display("FAIL raw_resp_c%0d: got %b", i, resp[0]); end
            if (i == 1) begin wr[0] = 1'b0; rd[0] = 1'b1; end
            if (i == 3) begin
                n_cmp++; if (rdata[0] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL raw_data: got %h want cafef00d", rdata[0]); end
                rd[0] = 1'b0;
            end
        end
    endtask

    task automatic test_abort();
        int f, c, nresp;
        logic [31:0] d;
        run_txn(2, 1'b0, 1'b1, 32'h150, 32'h1234_5678, 4'hF, f, c, d);
        n_cmp++; if (f !== 3) begin n_bad++; $display("FAIL abort_pre_lat: got %0d want 3", f); end
        wr[2] = 1'b1; ad[2] = 32'h150; wd[2] = 32'hFFFF_FFFF; wm[2] = 4'hF;
        @(negedge clk);
        wr[2] = 1'b0;
        nresp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp[2]) nresp++;
        end
        n_cmp++; if (nresp !== 0) begin n_bad++; $display("FAIL abort_resp: got %0d want 0", nresp); end
        n_cmp++; if (perr[2] !== PERR_EXP) begin n_bad++; $display("FAIL abort_perr: got %b want %b", perr[2], PERR_EXP); end
        run_txn(2, 1'b1, 1'b0, 32'h150, 32'h0, 4'h0, f, c, d);
        n_cmp++; if (d !== 32'h1234_5678) begin n_bad++; $display("FAIL abort_nocommit: got %h want 12345678", d); end
    endtask

    task automatic test_wrap_reset();
        int f, c;
        logic [31:0] d;
        run_txn(1, 1'b0, 1'b1, 32'h1004, 32'h0A0B_0C0D, 4'hF, f, c, d);
        run_txn(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, f, c, d);
        n_cmp++; if (d !== 32'h0A0B_0C0D) begin n_bad++; $display("FAIL wrap_alias: got %h want 0a0b0c0d", d); end
        wr[1] = 1'b1; ad[1] = 32'h4; wd[1] = 32'hFFFF_FFFF; wm[1] = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (resp !== 3'b000) begin n_bad++; $display("FAIL rst_mid_resp: got %b want 000", resp); end
        n_cmp++; if (perr !== 3'b000) begin n_bad++; $display("FAIL rst_mid_perr: got %b want 000", perr); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (rdata[k] !== 32'h0) begin n_bad++; $display("FAIL rst_mid_rdata%0d: got %h want 0", k, rdata[k]); end
        end
        rst = 1'b0; wr[1] = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp[1] !== 1'b0) begin n_bad++; $display("FAIL rst_post_resp: got %b want 0", resp[1]); end
        run_txn(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, f, c, d);
        n_cmp++; if (d !== 32'h0A0B_0C0D) begin n_bad++; $display("FAIL rst_nocommit: got %h want 0a0b0c0d", d); end
    endtask

    task automatic test_base_wrap();
        int f, c;
        logic [31:0] d;
        run_txn(2, 1'b0, 1'b1, 32'h104, 32'h55AA_55AA, 4'hF, f, c, d);
        run_txn(2, 1'b1, 1'b0, 32'h204, 32'h0, 4'h0, f, c, d);
        n_cmp++; if (d !== 32'h55AA_55AA) begin n_bad++; $display("FAIL base_wrap: got %h want 55aa55aa", d); end
    endtask

    task automatic test_protocol();
        int f, c;
        logic [31:0] d;
        rd[1] = 1'b1; wr[1] = 1'b1; ad[1] = 32'h8; wd[1] = 32'h9988_7766; wm[1] = 4'hF;
        @(negedge clk);
        n_cmp++; if (perr[1] !== PERR_EXP) begin n_bad++; $display("FAIL both_perr: got %b want %b", perr[1], PERR_EXP); end
        @(negedge clk);
        n_cmp++; if (resp[1] !== 1'b1) begin n_bad++; $display("FAIL both_resp: got %b want 1", resp[1]); end
        n_cmp++; if (rdata[1] !== 32'h0A0B_0C0D) begin n_bad++; $display("FAIL both_rdata_hold: got %h want 0a0b0c0d", rdata[1]); end
        rd[1] = 1'b0; wr[1] = 1'b0;
        @(negedge clk);
        run_txn(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, f, c, d);
        n_cmp++; if (d !== 32'h9988_7766) begin n_bad++; $display("FAIL both_as_write: got %h want 99887766", d); end
        n_cmp++; if (perr[1] !== PERR_EXP) begin n_bad++; $display("FAIL both_sticky: got %b want %b", perr[1], PERR_EXP); end

        rd[2] = 1'b1; ad[2] = 32'h104; wd[2] = 32'h0; wm[2] = 4'h0;
        @(negedge clk);
        ad[2] = 32'h108;
        @(negedge clk);
        n_cmp++; if (perr[2] !== PERR_EXP) begin n_bad++; $display("FAIL addr_change_perr: got %b want %b", perr[2], PERR_EXP); end
        @(negedge clk);
        n_cmp++; if (resp[2] !== 1'b1) begin n_bad++; $display("FAIL addr_change_resp: got %b want 1", resp[2]); end
        n_cmp++; if (rdata[2] !== 32'h55AA_55AA) begin n_bad++; $display("FAIL addr_change_data: got %h want 55aa55aa", rdata[2]); end
        rd[2] = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (perr !== {PERR_EXP, PERR_EXP, 1'b0}) begin n_bad++; $display("FAIL perr_sticky: got %b want %b", perr, {PERR_EXP, PERR_EXP, 1'b0}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (perr !== 3'b000) begin n_bad++; $display("FAIL perr_cleared: got %b want 000", perr); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        rd = '0;
        wr = '0;
        for (int k = 0; k < 3; k++) begin
            wm[k] = '0; ad[k] = '0; wd[k] = '0;
        end
        @(negedge clk);
        test_reset();
        test_basic_read();
        test_masked_write();
        test_back_to_back();
        test_read_after_write();
        test_abort();
        test_wrap_reset();
        test_base_wrap();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
